fifo_uart_tx: RTL and testbench

Serial transmit stage downstream of the 8-bit synchronous FIFO. Pops one byte at a time from the FIFO read port, then shifts it out as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity, 1 stop bit. Keeps popping and sending until the FIFO reports empty or transmission is disabled.

---
 rtl/fifo_uart_tx.sv | 142 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Serial transmitter fed from a synchronous FIFO read port: pops one byte per frame
// and sends start, 8 data bits LSB first, optional parity, and one stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic          PEN       = (PARITY_EN != 0);
  localparam logic          PODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_d, rd_d, busy_d, fd_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx         <= tx_d;
      fifo_rd_en <= rd_d;
      busy       <= busy_d;
      frame_done <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx;
    rd_d    = 1'b0;

    // Baud counter only runs while a bit is on the line; wraps at every bit boundary.
    if (state_q == START || state_q == DATA || state_q == PARITY || state_q == STOP)
      baud_d = bit_end ? '0 : baud_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_en && !fifo_empty) begin
          state_d = POP;
          rd_d    = 1'b1;
        end
      end
      POP: state_d = LOAD;
      LOAD: begin
        // Parity is latched with the byte since the shift register is consumed bit by bit.
        shift_d = fifo_data;
        par_d   = (^fifo_data) ^ PODD;
        tx_d    = 1'b0;
        baud_d  = '0;
        idx_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            idx_d = '0;
            if (PEN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (tx_en && !fifo_empty) begin
            state_d = POP;
            rd_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
    fd_d   = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Runs three transmitters (no parity, even, odd) against a FIFO model and a
// cycle-level waveform reference built from the frame format.
module tb_fifo_uart_tx;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic       push_vld;
  logic [7:0] push_data;
  logic [2:0] fifo_empty, rd_en, tx, busy, frame_done;
  logic [7:0] fifo_data [3] = '{default: 8'h00};
  logic [7:0] mem [3][256];
  logic [7:0] wp [3] = '{default: 8'h00};
  logic [7:0] rp [3] = '{default: 8'h00};

  int errors = 0;
  int checks = 0;
  int pushed = 0;

  int         ph [3] = '{default: -1};
  logic [10:0] bits [3];
  logic [10:0] rx [3];
  logic [7:0] log_b [3][256];
  logic       log_p [3][256];
  int         log_n [3] = '{default: 0};
  int         rd_cnt [3] = '{default: 0};
  int         fd_cnt [3] = '{default: 0};

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      assign fifo_empty[g] = (wp[g] == rp[g]);
      fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN((g > 0) ? 1 : 0), .PARITY_ODD((g == 2) ? 1 : 0)) u_dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty[g]), .fifo_data(fifo_data[g]),
        .fifo_rd_en(rd_en[g]), .tx(tx[g]), .busy(busy[g]), .frame_done(frame_done[g]));
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk_bits(input logic [7:0] b, input int i);
    logic [10:0] r;
    r = {1'b1, 1'b1, b, 1'b0};
    if (i > 0) r[9] = (^b) ^ (i == 2);
    return r;
  endfunction

  // synchronous FIFO: registered read data, one cycle after rd_en
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_en[i] && wp[i] != rp[i]) begin
        fifo_data[i] <= mem[i][rp[i]];
        rp[i] <= rp[i] + 8'd1;
      end
      if (push_vld) begin
        mem[i][wp[i]] <= push_data;
        wp[i] <= wp[i] + 8'd1;
      end
    end
  end

  // ph: -1 idle, 0 pop cycle, 1 load cycle, 2.. frame cycles
  always @(negedge clk) begin : mon
    int L;
    logic etx;
    for (int i = 0; i < 3; i++) begin
      L = (10 + ((i > 0) ? 1 : 0)) * N;
      if (rst) begin
        chk($sformatf("rst_tx%0d", i), 32'(tx[i]), 32'd1);
        chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
        chk($sformatf("rst_fd%0d", i), 32'(frame_done[i]), 32'd0);
        chk($sformatf("rst_rd%0d", i), 32'(rd_en[i]), 32'd0);
        ph[i] = -1;
      end else begin
        etx = (ph[i] < 2) ? 1'b1 : bits[i][(ph[i] - 2) / N];
        chk($sformatf("tx%0d", i), 32'(tx[i]), 32'(etx));
        chk($sformatf("rd_en%0d", i), 32'(rd_en[i]), 32'(ph[i] == 0));
        chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(ph[i] >= 0));
        chk($sformatf("frame_done%0d", i), 32'(frame_done[i]), 32'(ph[i] == L + 1));
        if (rd_en[i]) rd_cnt[i]++;
        if (frame_done[i]) fd_cnt[i]++;
        if (ph[i] >= 2 && (ph[i] - 2) % N == N / 2) rx[i][(ph[i] - 2) / N] = tx[i];
        if (ph[i] == -1) begin
          if (tx_en && !fifo_empty[i]) ph[i] = 0;
        end else if (ph[i] == 0) begin
          bits[i] = mk_bits(mem[i][rp[i]], i);
          ph[i] = 1;
        end else if (ph[i] == L + 1) begin
          log_b[i][log_n[i]] = rx[i][8:1];
          log_p[i][log_n[i]] = rx[i][9];
          log_n[i]++;
          ph[i] = (tx_en && !fifo_empty[i]) ? 0 : -1;
        end else begin
          ph[i]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b);
    push_vld = 1'b1;
    push_data = b;
    pushed++;
    step();
    push_vld = 1'b0;
  endtask

  task automatic wait_idle(input bit need_empty, input int budget);
    int c = 0;
    while (c < budget && !(ph[0] == -1 && ph[1] == -1 && ph[2] == -1 &&
                           (!need_empty || fifo_empty == 3'b111))) begin
      step();
      c++;
    end
    chk("wait_idle", 32'(c < budget), 32'd1);
  endtask

  task automatic wait_ph(input int target, input int budget);
    int c = 0;
    while (c < budget && ph[0] != target) begin
      step();
      c++;
    end
    chk("wait_ph", 32'(c < budget), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fdc;
    rst = 1'b1; tx_en = 1'b0; push_vld = 1'b0; push_data = 8'h00;
    repeat (3) step();
    chk("reset_tx", 32'(tx), 32'h7);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // empty FIFO with enable: no pops, line idle
    tx_en = 1'b1;
    repeat (100) step();
    chk("idle_rd_cnt", 32'(rd_cnt[0] + rd_cnt[1] + rd_cnt[2]), 32'd0);
    chk("idle_tx", 32'(tx), 32'h7);

    push(8'hA5);
    wait_idle(1'b1, 200);
    for (int i = 0; i < 3; i++) begin
      chk("a5_rd", 32'(rd_cnt[i]), 32'd1);
      chk("a5_fd", 32'(fd_cnt[i]), 32'd1);
      chk("a5_byte", 32'(log_b[i][0]), 32'hA5);
    end
    chk("a5_par_even", 32'(log_p[1][0]), 32'd0);
    chk("a5_par_odd", 32'(log_p[2][0]), 32'd1);
    chk("a5_busy", 32'(busy), 32'h0);
    chk("a5_empty", 32'(fifo_empty), 32'h7);

    push(8'h01); push(8'h80); push(8'hFF);
    wait_idle(1'b1, 600);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_rd", 32'(rd_cnt[i]), 32'd4);
      chk("b2b_fd", 32'(fd_cnt[i]), 32'd4);
      chk("b2b_b0", 32'(log_b[i][1]), 32'h01);
      chk("b2b_b1", 32'(log_b[i][2]), 32'h80);
      chk("b2b_b2", 32'(log_b[i][3]), 32'hFF);
    end

    push(8'h07);
    wait_idle(1'b1, 200);
    chk("07_byte", 32'(log_b[1][4]), 32'h07);
    chk("07_par_even", 32'(log_p[1][4]), 32'd1);
    chk("07_par_odd", 32'(log_p[2][4]), 32'd0);

    // drop enable mid-frame with a second byte queued
    push(8'h3C); push(8'hC3);
    wait_ph(2 + 2 * N, 100);
    tx_en = 1'b0;
    wait_idle(1'b0, 200);
    repeat (20) step();
    for (int i = 0; i < 3; i++) begin
      chk("hold_count", 32'(8'(wp[i] - rp[i])), 32'd1);
      chk("hold_rd", 32'(rd_cnt[i]), 32'd6);
      chk("hold_byte", 32'(log_b[i][5]), 32'h3C);
    end
    tx_en = 1'b1;
    wait_idle(1'b1, 200);
    for (int i = 0; i < 3; i++) chk("resume_byte", 32'(log_b[i][6]), 32'hC3);

    // reset during data bit 3: popped byte is lost
    push(8'h11); push(8'h22); push(8'h33);
    wait_ph(2 + 4 * N + 1, 200);
    fdc = fd_cnt[0];
    rst = 1'b1;
    #1;
    chk("rst_async_tx", 32'(tx), 32'h7);
    chk("rst_async_busy", 32'(busy), 32'h0);
    repeat (3) step();
    rst = 1'b0;
    chk("rst_no_fd", 32'(fd_cnt[0]), 32'(fdc));
    wait_idle(1'b1, 400);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_b0", 32'(log_b[i][7]), 32'h22);
      chk("post_rst_b1", 32'(log_b[i][8]), 32'h33);
      chk("post_rst_n", 32'(log_n[i]), 32'd9);
    end

    // randomized traffic and enable toggling
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 3 && 8'(wp[0] - rp[0]) < 8'd100) push(8'($urandom));
      else step();
      if ($urandom_range(0, 99) < 2) tx_en = ~tx_en;
    end
    tx_en = 1'b1;
    wait_idle(1'b1, 6000);
    for (int i = 0; i < 3; i++) begin
      chk("final_frames", 32'(log_n[i]), 32'(pushed - 1));
      chk("final_rd", 32'(rd_cnt[i]), 32'(pushed));
      chk("final_fd", 32'(fd_cnt[i]), 32'(pushed - 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
